// File: rtl/irq_scheduler.sv
// irq_scheduler: prioritised, nestable interrupt scheduler for the RV32 core.
// Edge-detects the external request lines into a pending set. It redirects the PC to a
// per-source vector when a pending source outranks the running level. On URET it restores
// the PC saved when that level was entered.
//
// Ports:
//   clk, rst_n          core clock, synchronous active-low reset
//   stall               pipeline stalled; blocks take, URET and ie writes
//   irq_in              request lines (index NUM_IRQ-1 is highest priority)
//   pc_next             fall-through PC, saved as EPC on a take
//   is_uret             decoder reports URET
//   csr_ie_we/_set      decoder reports CSRRSI (set=1) / CSRRCI (set=0) on the ie CSR
//   csr_imm0            zimm bit 0 of that CSR instruction
//   redirect            combinational PC override this cycle
//   redirect_pc         vector address (take) or saved EPC (URET)
//   pending, level, ie  architectural state
module irq_scheduler #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      NUM_IRQ    = 3,
  parameter logic [WIDTH-1:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [WIDTH-1:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic [NUM_IRQ-1:0]             irq_in,
  input  logic [WIDTH-1:0]               pc_next,
  input  logic                           is_uret,
  input  logic                           csr_ie_we,
  input  logic                           csr_ie_set,
  input  logic                           csr_imm0,
  output logic                           redirect,
  output logic [WIDTH-1:0]               redirect_pc,
  output logic [NUM_IRQ-1:0]             pending,
  output logic [$clog2(NUM_IRQ+1)-1:0]   level,
  output logic                           ie
);

  localparam int unsigned LvlW = $clog2(NUM_IRQ + 1);

  logic [NUM_IRQ-1:0] irq_q, irq_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [LvlW-1:0]    level_q, level_d;
  logic [LvlW-1:0]    sp_q, sp_d;
  logic               ie_q, ie_d;
  logic [WIDTH-1:0]   epc_q [NUM_IRQ];
  logic [WIDTH-1:0]   epc_d [NUM_IRQ];
  logic [LvlW-1:0]    lvl_q [NUM_IRQ];
  logic [LvlW-1:0]    lvl_d [NUM_IRQ];

  logic               cand_vld;
  logic [LvlW-1:0]    cand_idx;
  logic [WIDTH-1:0]   top_epc;
  logic [LvlW-1:0]    top_lvl;
  logic               uret_ev, take_ev;
  logic [WIDTH-1:0]   vec_pc;
  logic [NUM_IRQ-1:0] rise;

  // Highest-index pending source whose level (i+1) beats the running level.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (pending_q[i] && (LvlW'(i) >= level_q)) begin
        cand_vld = 1'b1;
        cand_idx = LvlW'(i);
      end
    end
  end

  // Stack top is the entry just below the stack pointer.
  always_comb begin
    top_epc = '0;
    top_lvl = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (LvlW'(i + 1) == sp_q) begin
        top_epc = epc_q[i];
        top_lvl = lvl_q[i];
      end
    end
  end

  assign uret_ev = ~stall & is_uret & (level_q != '0);
  assign take_ev = ~stall & ~uret_ev & ie_q & cand_vld;
  assign vec_pc  = VEC_BASE + VEC_STRIDE * WIDTH'(cand_idx);
  assign rise    = irq_in & ~irq_q;

  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    if (rst_n) begin
      redirect = uret_ev | take_ev;
      if (uret_ev) begin
        redirect_pc = top_epc;
      end else if (take_ev) begin
        redirect_pc = vec_pc;
      end
    end
  end

  always_comb begin
    irq_d     = irq_in;
    pending_d = pending_q;
    level_d   = level_q;
    sp_d      = sp_q;
    ie_d      = ie_q;
    epc_d     = epc_q;
    lvl_d     = lvl_q;

    if (csr_ie_we && !stall && csr_imm0) begin
      ie_d = csr_ie_set;
    end

    if (uret_ev) begin
      level_d = top_lvl;
      sp_d    = sp_q - LvlW'(1);
    end else if (take_ev) begin
      level_d = cand_idx + LvlW'(1);
      sp_d    = sp_q + LvlW'(1);
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (LvlW'(i) == cand_idx) pending_d[i] = 1'b0;
        if (LvlW'(i) == sp_q) begin
          epc_d[i] = pc_next;
          lvl_d[i] = level_q;
        end
      end
    end

    // A new edge on a source being taken keeps it pending.
    pending_d = pending_d | rise;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_q     <= '0;
      pending_q <= '0;
      level_q   <= '0;
      sp_q      <= '0;
      ie_q      <= 1'b0;
      for (int i = 0; i < NUM_IRQ; i++) begin
        epc_q[i] <= '0;
        lvl_q[i] <= '0;
      end
    end else begin
      irq_q     <= irq_d;
      pending_q <= pending_d;
      level_q   <= level_d;
      sp_q      <= sp_d;
      ie_q      <= ie_d;
      epc_q     <= epc_d;
      lvl_q     <= lvl_d;
    end
  end

  assign pending = pending_q;
  assign level   = level_q;
  assign ie      = ie_q;

endmodule

// File: tb/tb_irq_scheduler.sv
module tb_irq_scheduler;

  localparam int unsigned NUM_IRQ    = 3;
  localparam logic [31:0] VEC_BASE   = 32'h0000_0100;
  localparam logic [31:0] VEC_STRIDE = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst_n, stall, is_uret, csr_ie_we, csr_ie_set, csr_imm0;
  logic [2:0]  irq_in;
  logic [31:0] pc_next;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  pending;
  logic [1:0]  level;
  logic        ie;

  always #5 clk = ~clk;

  irq_scheduler #(
    .WIDTH      (32),
    .NUM_IRQ    (NUM_IRQ),
    .VEC_BASE   (VEC_BASE),
    .VEC_STRIDE (VEC_STRIDE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .irq_in      (irq_in),
    .pc_next     (pc_next),
    .is_uret     (is_uret),
    .csr_ie_we   (csr_ie_we),
    .csr_ie_set  (csr_ie_set),
    .csr_imm0    (csr_imm0),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pending     (pending),
    .level       (level),
    .ie          (ie)
  );

  typedef struct {
    bit          rst_n, stall;
    logic [2:0]  irq;
    logic [31:0] pc;
    bit          uret, we, set, imm0;
    bit          e_red;
    logic [31:0] e_pc;
    logic [2:0]  e_pend;
    int          e_lvl;
    bit          e_ie;
  } vec_t;

  vec_t tbl[$];

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: pending set, running level, ie and a LIFO of saved frames.
  typedef struct {
    logic [31:0] epc;
    int          lvl;
  } frame_t;

  frame_t      m_stk[$];
  logic [2:0]  m_pend = '0;
  logic [2:0]  m_prev = '0;
  int          m_level = 0;
  bit          m_ie = 1'b0;

  function automatic void add(bit r, bit s, logic [2:0] irq, logic [31:0] pc, bit u, bit we,
                              bit set, bit imm0, bit ered, logic [31:0] epc, logic [2:0] epend,
                              int elvl, bit eie);
    vec_t v;
    v.rst_n = r; v.stall = s; v.irq = irq; v.pc = pc; v.uret = u; v.we = we; v.set = set;
    v.imm0 = imm0; v.e_red = ered; v.e_pc = epc; v.e_pend = epend; v.e_lvl = elvl; v.e_ie = eie;
    tbl.push_back(v);
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int m_cand();
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (m_pend[i] && (i + 1 > m_level)) return i;
    end
    return -1;
  endfunction

  task automatic m_expect(output bit red, output logic [31:0] pc);
    int c;
    red = 1'b0;
    pc  = '0;
    c   = m_cand();
    if (rst_n && !stall) begin
      if (is_uret && m_level != 0) begin
        red = 1'b1;
        pc  = m_stk[$].epc;
      end else if (m_ie && c >= 0) begin
        red = 1'b1;
        pc  = VEC_BASE + VEC_STRIDE * 32'(c);
      end
    end
  endtask

  task automatic m_update();
    logic [2:0] rise;
    bit         u, t;
    int         c;
    frame_t     f;
    if (!rst_n) begin
      m_pend = '0; m_prev = '0; m_level = 0; m_ie = 1'b0;
      m_stk.delete();
      return;
    end
    rise   = irq_in & ~m_prev;
    m_prev = irq_in;
    c = m_cand();
    u = !stall && is_uret && m_level != 0;
    t = !stall && !u && m_ie && c >= 0;
    if (u) begin
      f = m_stk.pop_back();
      m_level = f.lvl;
    end else if (t) begin
      f.epc = pc_next;
      f.lvl = m_level;
      m_stk.push_back(f);
      m_level  = c + 1;
      m_pend[c] = 1'b0;
    end
    if (csr_ie_we && !stall && csr_imm0) m_ie = csr_ie_set;
    m_pend = m_pend | rise;
  endtask

  task automatic drive(vec_t v);
    rst_n = v.rst_n; stall = v.stall; irq_in = v.irq; pc_next = v.pc;
    is_uret = v.uret; csr_ie_we = v.we; csr_ie_set = v.set; csr_imm0 = v.imm0;
  endtask

  // Inputs are driven 1 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic step(vec_t v, bit use_tbl, int idx);
    bit          red;
    logic [31:0] pc;
    drive(v);
    @(negedge clk);
    if (use_tbl) begin
      cmp($sformatf("row%0d.redirect", idx), 32'(redirect), 32'(v.e_red));
      if (v.e_red || !v.rst_n) cmp($sformatf("row%0d.redirect_pc", idx), redirect_pc, v.e_pc);
      cmp($sformatf("row%0d.pending", idx), 32'(pending), 32'(v.e_pend));
      cmp($sformatf("row%0d.level", idx), 32'(level), 32'(v.e_lvl));
      cmp($sformatf("row%0d.ie", idx), 32'(ie), 32'(v.e_ie));
    end else begin
      m_expect(red, pc);
      cmp("rnd.redirect", 32'(redirect), 32'(red));
      if (red || !rst_n) cmp("rnd.redirect_pc", redirect_pc, pc);
      cmp("rnd.pending", 32'(pending), 32'(m_pend));
      cmp("rnd.level", 32'(level), 32'(m_level));
      cmp("rnd.ie", 32'(ie), 32'(m_ie));
    end
    m_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    //  rst stl irq    pc       uret we set imm0  red  rpc      pend   lvl ie
    add(0, 0, 3'b000, 32'h0,   0, 0, 0, 0,     0, 32'h0,   3'b000, 0, 0);  // reset
    add(1, 0, 3'b000, 32'h0,   0, 1, 1, 1,     0, 32'h0,   3'b000, 0, 0);  // CSRRSI ie
    // T1
    add(1, 0, 3'b001, 32'h40,  0, 0, 0, 0,     0, 32'h0,   3'b000, 0, 1);
    add(1, 0, 3'b000, 32'h40,  0, 0, 0, 0,     1, 32'h100, 3'b001, 0, 1);
    add(1, 0, 3'b000, 32'h0,   0, 0, 0, 0,     0, 32'h0,   3'b000, 1, 1);
    // T2
    add(1, 0, 3'b100, 32'h104, 0, 0, 0, 0,     0, 32'h0,   3'b000, 1, 1);
    add(1, 0, 3'b000, 32'h104, 0, 0, 0, 0,     1, 32'h120, 3'b100, 1, 1);
    add(1, 0, 3'b000, 32'h124, 1, 0, 0, 0,     1, 32'h104, 3'b000, 3, 1);
    add(1, 0, 3'b000, 32'h108, 1, 0, 0, 0,     1, 32'h40,  3'b000, 1, 1);
    add(1, 0, 3'b000, 32'h0,   0, 0, 0, 0,     0, 32'h0,   3'b000, 0, 1);
    // T3
    add(1, 0, 3'b100, 32'h200, 0, 0, 0, 0,     0, 32'h0,   3'b000, 0, 1);
    add(1, 0, 3'b000, 32'h200, 0, 0, 0, 0,     1, 32'h120, 3'b100, 0, 1);
    add(1, 0, 3'b010, 32'h0,   0, 0, 0, 0,     0, 32'h0,   3'b000, 3, 1);
    add(1, 0, 3'b000, 32'h0,   0, 0, 0, 0,     0, 32'h0,   3'b010, 3, 1);
    add(1, 0, 3'b000, 32'h0,   1, 0, 0, 0,     1, 32'h200, 3'b010, 3, 1);
    add(1, 0, 3'b000, 32'h300, 0, 0, 0, 0,     1, 32'h110, 3'b010, 0, 1);
    add(1, 0, 3'b000, 32'h0,   1, 0, 0, 0,     1, 32'h300, 3'b000, 2, 1);
    // T4: ie off, held level is one request, enable then take exactly once
    add(1, 0, 3'b000, 32'h0,   0, 1, 0, 1,     0, 32'h0,   3'b000, 0, 1);
    add(1, 0, 3'b010, 32'h0,   0, 0, 0, 0,     0, 32'h0,   3'b000, 0, 0);
    add(1, 0, 3'b010, 32'h0,   0, 0, 0, 0,     0, 32'h0,   3'b010, 0, 0);
    add(1, 0, 3'b010, 32'h0,   0, 0, 0, 0,     0, 32'h0,   3'b010, 0, 0);
    add(1, 0, 3'b010, 32'h0,   0, 0, 0, 0,     0, 32'h0,   3'b010, 0, 0);
    add(1, 0, 3'b010, 32'h0,   0, 0, 0, 0,     0, 32'h0,   3'b010, 0, 0);
    add(1, 0, 3'b000, 32'h0,   0, 1, 1, 1,     0, 32'h0,   3'b010, 0, 0);
    add(1, 0, 3'b000, 32'h500, 0, 0, 0, 0,     1, 32'h110, 3'b010, 0, 1);
    add(1, 0, 3'b000, 32'h0,   0, 0, 0, 0,     0, 32'h0,   3'b000, 2, 1);
    add(1, 0, 3'b000, 32'h0,   1, 0, 0, 0,     1, 32'h500, 3'b000, 2, 1);
    // T5: URET at level 0 ignored; imm0=0 leaves ie; URET beats a candidate
    add(1, 0, 3'b000, 32'h0,   1, 0, 0, 0,     0, 32'h0,   3'b000, 0, 1);
    add(1, 0, 3'b000, 32'h0,   0, 1, 0, 0,     0, 32'h0,   3'b000, 0, 1);
    add(1, 0, 3'b001, 32'h600, 0, 0, 0, 0,     0, 32'h0,   3'b000, 0, 1);
    add(1, 0, 3'b000, 32'h600, 0, 0, 0, 0,     1, 32'h100, 3'b001, 0, 1);
    add(1, 0, 3'b100, 32'h0,   0, 0, 0, 0,     0, 32'h0,   3'b000, 1, 1);
    add(1, 0, 3'b000, 32'h0,   1, 0, 0, 0,     1, 32'h600, 3'b100, 1, 1);
    add(1, 0, 3'b000, 32'h700, 0, 0, 0, 0,     1, 32'h120, 3'b100, 0, 1);
    add(1, 0, 3'b000, 32'h0,   1, 0, 0, 0,     1, 32'h700, 3'b000, 3, 1);
    // T6: stall blocks take; reset mid-ISR
    add(1, 0, 3'b001, 32'h0,   0, 0, 0, 0,     0, 32'h0,   3'b000, 0, 1);
    add(1, 1, 3'b000, 32'h0,   0, 0, 0, 0,     0, 32'h0,   3'b001, 0, 1);
    add(1, 1, 3'b000, 32'h0,   0, 0, 0, 0,     0, 32'h0,   3'b001, 0, 1);
    add(1, 0, 3'b000, 32'h800, 0, 0, 0, 0,     1, 32'h100, 3'b001, 0, 1);
    add(1, 0, 3'b010, 32'h0,   0, 0, 0, 0,     0, 32'h0,   3'b000, 1, 1);
    add(1, 0, 3'b000, 32'h900, 0, 0, 0, 0,     1, 32'h110, 3'b010, 1, 1);
    add(0, 0, 3'b001, 32'h0,   1, 0, 0, 0,     0, 32'h0,   3'b000, 2, 1);
    add(1, 0, 3'b000, 32'h0,   0, 0, 0, 0,     0, 32'h0,   3'b000, 0, 0);

    // Two reset cycles bring DUT and model to a known state before any check.
    v = tbl[0];
    drive(v);
    @(posedge clk);
    #1;
    step(v, 1'b0, 0);

    foreach (tbl[i]) step(tbl[i], 1'b1, i);

    for (int n = 0; n < 3000; n++) begin
      v.rst_n = ($urandom_range(0, 199) != 0);
      v.stall = ($urandom_range(0, 4) == 0);
      v.irq   = ($urandom_range(0, 2) == 0) ? 3'($urandom) : irq_in;
      v.pc    = $urandom & 32'hffff_fffc;
      v.uret  = ($urandom_range(0, 5) == 0);
      v.we    = ($urandom_range(0, 7) == 0);
      v.set   = ($urandom_range(0, 3) != 0);
      v.imm0  = ($urandom_range(0, 3) != 0);
      step(v, 1'b0, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
